// File: rtl/vga_scan_timing.sv
// Raster scan generator: pixel-rate divider, row/col counters, blanking flag,
// frame counter and pixel-tick-delayed de/hsync/vsync for the display stage.
module vga_scan_timing #(
  parameter int CLK_DIV    = 2,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_POL   = 0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [9:0] row,
  output logic [9:0] col,
  output logic       pe,
  output logic       vnotactive,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DLY_N = (SYNC_DELAY == 0) ? 1 : SYNC_DELAY;

  localparam logic [9:0] C_H_VIS    = 10'(H_VIS);
  localparam logic [9:0] C_H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] C_HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] C_HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] C_V_VIS    = 10'(V_VIS);
  localparam logic [9:0] C_V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] C_VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] C_VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [2:0] C_DIV_LAST = 3'(CLK_DIV - 1);
  localparam logic       C_ACT      = 1'(SYNC_POL);

  if (CLK_DIV < 1 || CLK_DIV > 8 || SYNC_DELAY < 0 || SYNC_DELAY > 4 ||
      SYNC_POL < 0 || SYNC_POL > 1 || H_VIS < 1 || H_FP < 1 || H_SYNC < 1 ||
      H_BP < 1 || V_VIS < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      H_TOT > 1024 || V_TOT > 1024) begin : g_bad_params
    $error("vga_scan_timing: illegal parameter set");
  end

  logic [2:0]       r_div;
  logic             r_pe;
  logic [9:0]       r_row;
  logic [9:0]       r_col;
  logic             r_vna;
  logic             r_fstart;
  logic [7:0]       r_fcnt;
  logic [DLY_N-1:0] r_de_dly;
  logic [DLY_N-1:0] r_hs_dly;
  logic [DLY_N-1:0] r_vs_dly;

  logic [2:0] w_div_nxt;
  logic [9:0] w_row_nxt;
  logic [9:0] w_col_nxt;
  logic       w_eol;
  logic       w_eof;
  logic       w_de_raw;
  logic       w_hs_lvl;
  logic       w_vs_lvl;

  // Next-state scan position and raw sync/visible decode of the current position
  always_comb begin
    w_div_nxt = (r_div == C_DIV_LAST) ? 3'd0 : r_div + 3'd1;
    w_eol     = (r_col == C_H_LAST);
    w_eof     = w_eol && (r_row == C_V_LAST);
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (r_pe) begin
      if (w_eol) begin
        w_col_nxt = 10'd0;
        w_row_nxt = w_eof ? 10'd0 : r_row + 10'd1;
      end else begin
        w_col_nxt = r_col + 10'd1;
      end
    end else begin
      w_row_nxt = r_row;
      w_col_nxt = r_col;
    end
    w_de_raw = (r_col < C_H_VIS) && (r_row < C_V_VIS);
    w_hs_lvl = ((r_col >= C_HS_BEG) && (r_col <= C_HS_END)) ? C_ACT : ~C_ACT;
    w_vs_lvl = ((r_row >= C_VS_BEG) && (r_row <= C_VS_END)) ? C_ACT : ~C_ACT;
  end

  // Divider, scan counters, frame bookkeeping and the pixel-tick delay line
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_div    <= 3'd0;
      r_pe     <= 1'b0;
      r_row    <= 10'd0;
      r_col    <= 10'd0;
      r_vna    <= 1'b0;
      r_fstart <= 1'b0;
      r_fcnt   <= 8'd0;
      r_de_dly <= '0;
      r_hs_dly <= {DLY_N{~C_ACT}};
      r_vs_dly <= {DLY_N{~C_ACT}};
    end else begin
      r_div    <= w_div_nxt;
      r_pe     <= (w_div_nxt == C_DIV_LAST);
      r_row    <= w_row_nxt;
      r_col    <= w_col_nxt;
      r_vna    <= (w_row_nxt >= C_V_VIS);
      r_fstart <= r_pe && w_eof;
      if (r_pe && w_eof) begin
        r_fcnt <= r_fcnt + 8'd1;
      end
      if (r_pe) begin
        for (int i = DLY_N - 1; i > 0; i--) begin
          r_de_dly[i] <= r_de_dly[i-1];
          r_hs_dly[i] <= r_hs_dly[i-1];
          r_vs_dly[i] <= r_vs_dly[i-1];
        end
        r_de_dly[0] <= w_de_raw;
        r_hs_dly[0] <= w_hs_lvl;
        r_vs_dly[0] <= w_vs_lvl;
      end
    end
  end

  assign row         = r_row;
  assign col         = r_col;
  assign pe          = r_pe;
  assign vnotactive  = r_vna;
  assign frame_start = r_fstart;
  assign frame_cnt   = r_fcnt;

  // A zero-depth build taps the raw decode directly
  if (SYNC_DELAY == 0) begin : g_nodly
    assign de    = w_de_raw;
    assign hsync = w_hs_lvl;
    assign vsync = w_vs_lvl;
  end else begin : g_dly
    assign de    = r_de_dly[DLY_N-1];
    assign hsync = r_hs_dly[DLY_N-1];
    assign vsync = r_vs_dly[DLY_N-1];
  end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench: three builds (default, slow divider with deep delay, CLK_DIV=1 zero delay)
// driven with random reset points and checked every CLK against a tick-count reference model.
module tb_vga_scan_timing;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic       pe;
    logic       vna;
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [7:0] fcnt;
  } obs_t;

  // per-build parameters: 0 = default, 1 = small slow, 2 = small fast
  int p_k   [3] = '{2, 3, 1};
  int p_hv  [3] = '{640, 8, 10};
  int p_hfp [3] = '{16, 2, 1};
  int p_hs  [3] = '{96, 3, 2};
  int p_hbp [3] = '{48, 2, 3};
  int p_vv  [3] = '{480, 4, 3};
  int p_vfp [3] = '{10, 1, 2};
  int p_vs  [3] = '{2, 2, 1};
  int p_vbp [3] = '{33, 1, 1};
  int p_pol [3] = '{0, 1, 0};
  int p_dly [3] = '{1, 2, 0};
  string names [3] = '{"default", "slow_d2", "fast_d0"};

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [9:0] row_s  [3];
  logic [9:0] col_s  [3];
  logic       pe_s   [3];
  logic       vna_s  [3];
  logic       de_s   [3];
  logic       hs_s   [3];
  logic       vs_s   [3];
  logic       fs_s   [3];
  logic [7:0] fcnt_s [3];
  obs_t       got    [3];

  vga_scan_timing u_dut0 (
    .CLK(CLK), .RST(RST), .row(row_s[0]), .col(col_s[0]), .pe(pe_s[0]),
    .vnotactive(vna_s[0]), .de(de_s[0]), .hsync(hs_s[0]), .vsync(vs_s[0]),
    .frame_start(fs_s[0]), .frame_cnt(fcnt_s[0])
  );

  vga_scan_timing #(
    .CLK_DIV(3), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1), .SYNC_DELAY(2)
  ) u_dut1 (
    .CLK(CLK), .RST(RST), .row(row_s[1]), .col(col_s[1]), .pe(pe_s[1]),
    .vnotactive(vna_s[1]), .de(de_s[1]), .hsync(hs_s[1]), .vsync(vs_s[1]),
    .frame_start(fs_s[1]), .frame_cnt(fcnt_s[1])
  );

  vga_scan_timing #(
    .CLK_DIV(1), .H_VIS(10), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_VIS(3), .V_FP(2), .V_SYNC(1), .V_BP(1), .SYNC_POL(0), .SYNC_DELAY(0)
  ) u_dut2 (
    .CLK(CLK), .RST(RST), .row(row_s[2]), .col(col_s[2]), .pe(pe_s[2]),
    .vnotactive(vna_s[2]), .de(de_s[2]), .hsync(hs_s[2]), .vsync(vs_s[2]),
    .frame_start(fs_s[2]), .frame_cnt(fcnt_s[2])
  );

  // Pack each build's outputs for whole-vector comparison
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      got[k] = {row_s[k], col_s[k], pe_s[k], vna_s[k], de_s[k], hs_s[k],
                vs_s[k], fs_s[k], fcnt_s[k]};
    end
  end

  int   n_vec = 0;
  int   n_err = 0;
  int   c_m [3];
  int   t_m [3];
  bit   pe_m [3];
  obs_t q0 [$];
  obs_t q1 [$];
  obs_t q2 [$];

  function automatic int h_tot(input int k);
    return p_hv[k] + p_hfp[k] + p_hs[k] + p_hbp[k];
  endfunction

  function automatic int frame_len(input int k);
    return h_tot(k) * (p_vv[k] + p_vfp[k] + p_vs[k] + p_vbp[k]);
  endfunction

  // Expected outputs after t pixel ticks since reset; delayed flags look back SYNC_DELAY ticks
  function automatic obs_t expect_at(input int k, input bit fs);
    obs_t e;
    int   ht   = h_tot(k);
    int   fl   = frame_len(k);
    int   pos  = t_m[k] % fl;
    int   dpos;
    int   r;
    int   c;
    bit   hs_act = 1'b0;
    bit   vs_act = 1'b0;
    e.row  = 10'(pos / ht);
    e.col  = 10'(pos % ht);
    e.pe   = pe_m[k];
    e.vna  = ((pos / ht) >= p_vv[k]);
    e.fs   = fs;
    e.fcnt = 8'((t_m[k] / fl) % 256);
    e.de   = 1'b0;
    if (t_m[k] >= p_dly[k]) begin
      dpos   = (t_m[k] - p_dly[k]) % fl;
      r      = dpos / ht;
      c      = dpos % ht;
      e.de   = (c < p_hv[k]) && (r < p_vv[k]);
      hs_act = (c >= p_hv[k] + p_hfp[k]) && (c < p_hv[k] + p_hfp[k] + p_hs[k]);
      vs_act = (r >= p_vv[k] + p_vfp[k]) && (r < p_vv[k] + p_vfp[k] + p_vs[k]);
    end
    e.hs = hs_act ? p_pol[k][0] : !p_pol[k][0];
    e.vs = vs_act ? p_pol[k][0] : !p_pol[k][0];
    return e;
  endfunction

  // Advance the reference by one CLK edge with the given reset level and queue the expectation
  task automatic model_step(input int k, input bit rst_n);
    bit   fs = 1'b0;
    obs_t e;
    if (!rst_n) begin
      c_m[k]  = 0;
      t_m[k]  = 0;
      pe_m[k] = 1'b0;
    end else begin
      if (pe_m[k]) begin
        t_m[k] = t_m[k] + 1;
        fs     = ((t_m[k] % frame_len(k)) == 0);
      end
      c_m[k]  = c_m[k] + 1;
      pe_m[k] = ((c_m[k] % p_k[k]) == (p_k[k] - 1));
    end
    e = expect_at(k, fs);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input bit v);
    @(negedge CLK);
    RST = v;
    @(posedge CLK);
    for (int k = 0; k < 3; k++) model_step(k, v);
  endtask

  task automatic compare(input int k, input obs_t e);
    n_vec = n_vec + 1;
    if (got[k] !== e) begin
      n_err = n_err + 1;
      if (n_err <= 20)
        $display("FAIL %s @%0t row got %0d exp %0d, col got %0d exp %0d, pe/vna/de/hs/vs/fs got %b%b%b%b%b%b exp %b%b%b%b%b%b, frame_cnt got %0d exp %0d",
                 names[k], $time, got[k].row, e.row, got[k].col, e.col,
                 got[k].pe, got[k].vna, got[k].de, got[k].hs, got[k].vs, got[k].fs,
                 e.pe, e.vna, e.de, e.hs, e.vs, e.fs, got[k].fcnt, e.fcnt);
    end
  endtask

  // Monitor: pop one expectation per build per CLK and compare away from the active edge
  always @(negedge CLK) begin
    if (q0.size() > 0) compare(0, q0.pop_front());
    if (q1.size() > 0) compare(1, q1.pop_front());
    if (q2.size() > 0) compare(2, q2.pop_front());
  end

  initial begin
    repeat (3) drive(1'b0);
    for (int seg = 0; seg < 8; seg++) begin
      repeat ($urandom_range(200, 1500)) drive(1'b1);
      repeat ($urandom_range(1, 3)) drive(1'b0);
    end
    // long uninterrupted run: fast build passes 256 frames and wraps frame_cnt
    repeat (31000) drive(1'b1);
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Upstream raster generator for the tic-tac-toe display stage. Produces the pixel scan position (row, col) and the blanking flag (vnotactive) that the display stage consumes, plus the monitor sync pulses.
- Sync pulses are delayed to line up with the display stage's registered RGB outputs.
- Default timing is 640x480@60 with a 25 MHz pixel rate, derived from the board clock through a clock-enable divider.

Parameters:
- CLK_DIV, 2, board clocks per pixel (1..8); pixel tick pe asserted once every CLK_DIV cycles
- H_VIS, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- SYNC_DELAY, 1, pixel ticks of delay applied to hsync/vsync/de (0..4)

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous active-low reset, sampled on rising CLK
- row  out  10  current line, 0..V_TOT-1 (V_TOT = V_VIS+V_FP+V_SYNC+V_BP = 525)
- col  out  10  current pixel, 0..H_TOT-1 (H_TOT = 800)
- pe  out  1  pixel-tick strobe, high for 1 CLK
- vnotactive  out  1  high while row >= V_VIS (vertical blanking)
- de  out  1  visible-pixel flag, delayed SYNC_DELAY ticks
- hsync  out  1  delayed horizontal sync
- vsync  out  1  delayed vertical sync
- frame_start  out  1  1-CLK pulse on the tick where row/col become 0/0
- frame_cnt  out  8  frames completed, wraps 255->0

Behaviour:
- Reset (RST=0 at rising CLK): div counter=0, row=0, col=0, pe=0, frame_cnt=0, frame_start=0, vnotactive=0, de=0; hsync=vsync=~SYNC_POL (inactive); delay line filled with inactive values. Reset mid-frame restarts the frame at 0/0 on the next cycle; no partial line is completed.
- Divider: counts 0..CLK_DIV-1; pe=1 in the cycle the count equals CLK_DIV-1. With CLK_DIV=1, pe is constantly 1 after reset.
- Scan: on pe, col<=col+1. At col==H_TOT-1, col<=0 and row<=row+1. At row==V_TOT-1 with col==H_TOT-1, row<=0, frame_cnt<=frame_cnt+1, and frame_start=1 for that single CLK. row and col are never updated outside pe.
- vnotactive: registered, combinational decode of the updated row; goes high in the same cycle row becomes 480 and low in the same cycle row returns to 0.
- Raw decode from the current row/col:
  - de_raw = col<H_VIS && row<V_VIS
  - hs_raw active when col in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751]
  - vs_raw active when row in [490,491], for all columns of those lines
- Delay line: a SYNC_DELAY-deep shift register advanced only on pe. Outputs are stage SYNC_DELAY; with SYNC_DELAY=0, outputs equal the raw decode.
  - Default 1 matches the one-cycle RGB register in the display stage.
- Parameter legality: out-of-range parameters are a synthesis-time error (generate check).

Test Plan:
- Reset then 2*H_TOT*V_TOT*CLK_DIV cycles -> frame_start pulses exactly twice, 840000 CLK apart; frame_cnt=2; pe period = 2 CLK.
- Line timing, SYNC_DELAY=1 -> hsync low for exactly 96 pe ticks, first low tick one pe after col=656; de high for 640 ticks per visible line.
- Frame boundary -> vnotactive rises when row=480,col=0 and falls when row=0; vsync low for 2*800 ticks starting one pe after row=490,col=0.
- Wrap: row=524,col=799 plus pe -> row=0, col=0, frame_start=1 for 1 CLK; after 255 frames, next frame -> frame_cnt=0.
- Reset at row=300,col=400 -> next CLK row=0, col=0, hsync=vsync=1, de=0; frame_cnt=0.
- CLK_DIV=1, SYNC_DELAY=0 build -> hsync low exactly while col in 656..751; row advances every 800 CLK.
